// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with valid/ready byte delivery and framing/overrun error pulses
module uart_rx #(
  parameter int CLKS_PER_BIT = 8192
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t state;
  logic [1:0] sync;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic rx_s;
  assign rx_s = sync[1];
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync      <= 2'b11;
      state     <= IDLE;
      cnt       <= '0;
      idx       <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync      <= {sync[0], rx};
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) state <= START;
        end
        START: begin
          if (cnt == HALF) begin
            cnt   <= '0;
            idx   <= '0;
            state <= rx_s ? IDLE : DATA;
          end else cnt <= cnt + 1'b1;
        end
        DATA: begin
          if (cnt == LAST) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            if (idx == 3'd7) state <= STOP;
            else idx <= idx + 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        STOP: begin
          if (cnt == LAST) begin
            cnt <= '0;
            if (rx_s) begin
              state <= IDLE;
              if (!rx_valid || rx_ready) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else overrun <= 1'b1;
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end else cnt <= cnt + 1'b1;
        end
        BRK: begin
          cnt <= '0;
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with directed 8N1 frames at 16 clocks per bit
module tb_uart_rx;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx = 1'b1;
  logic rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun, busy;
  int pass_cnt = 0;
  int total_cnt = 0;
  int n_del = 0;
  int n_fe = 0;
  int n_ov = 0;
  logic [7:0] exp_q[$];
  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .frame_err(frame_err), .overrun(overrun), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask
  task automatic fail(input string name);
    total_cnt++;
    $display("FAIL %s: got event, expected none at %0t", name, $time);
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) fail("unexpected_valid");
        else chk("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
        n_del++;
      end
      if (frame_err) n_fe++;
      if (overrun) n_ov++;
      if (frame_err && overrun) fail("fe_ov_same_cycle");
    end
  end
  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic drive_bit(input logic v);
    rx = v;
    clks(CPB);
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
  endtask
  task automatic drain(input string name);
    int k = 0;
    while (exp_q.size() != 0 && k < 4 * CPB) begin
      clks(1);
      k++;
    end
    chk(name, exp_q.size(), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
  initial begin
    int d0, f0, o0;
    clks(3);
    chk("reset_outputs", {19'h0, rx_data, rx_valid, frame_err, overrun, busy}, 0);
    reset = 1'b0;
    clks(4);
    // 1: single byte with ready held high
    d0 = n_del; f0 = n_fe; o0 = n_ov;
    exp_q.push_back(8'hA5);
    send(8'hA5, 1'b1);
    drain("t1_drain");
    clks(4);
    chk("t1_valid_count", n_del - d0, 1);
    chk("t1_errors", (n_fe - f0) + (n_ov - o0), 0);
    chk("t1_busy", {31'h0, busy}, 0);
    // 2: short glitch is rejected at mid start bit
    d0 = n_del; f0 = n_fe; o0 = n_ov;
    rx = 1'b0;
    clks(4);
    rx = 1'b1;
    clks(12);
    chk("t2_busy", {31'h0, busy}, 0);
    chk("t2_no_events", (n_del - d0) + (n_fe - f0) + (n_ov - o0), 0);
    // 3: framing error, break, then recovery
    d0 = n_del; f0 = n_fe; o0 = n_ov;
    send(8'h3C, 1'b0);
    clks(40);
    chk("t3_busy_in_break", {31'h0, busy}, 1);
    chk("t3_frame_err", n_fe - f0, 1);
    rx = 1'b1;
    clks(CPB);
    chk("t3_busy_after_break", {31'h0, busy}, 0);
    exp_q.push_back(8'h81);
    send(8'h81, 1'b1);
    drain("t3_drain");
    chk("t3_valid_count", n_del - d0, 1);
    chk("t3_overrun", n_ov - o0, 0);
    // 4: overrun while first byte is held
    d0 = n_del; f0 = n_fe; o0 = n_ov;
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send(8'h11, 1'b1);
    chk("t4_valid_held", {31'h0, rx_valid}, 1);
    send(8'h22, 1'b1);
    chk("t4_overrun", n_ov - o0, 1);
    chk("t4_data_kept", {24'h0, rx_data}, 32'h11);
    chk("t4_valid_still", {31'h0, rx_valid}, 1);
    rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_valid_dropped", {31'h0, rx_valid}, 0);
    chk("t4_one_delivery", n_del - d0, 1);
    chk("t4_frame_err", n_fe - f0, 0);
    // 5: reset mid-frame
    clks(2);
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    drive_bit(1'b1);
    reset = 1'b1;
    rx = 1'b1;
    @(negedge clk);
    chk("t5_reset_outputs", {19'h0, rx_data, rx_valid, frame_err, overrun, busy}, 0);
    clks(3);
    reset = 1'b0;
    clks(4);
    d0 = n_del; f0 = n_fe; o0 = n_ov;
    exp_q.push_back(8'h5A);
    send(8'h5A, 1'b1);
    drain("t5_drain");
    chk("t5_valid_count", n_del - d0, 1);
    chk("t5_errors", (n_fe - f0) + (n_ov - o0), 0);
    // 6: back-to-back frames with no idle gap
    d0 = n_del; f0 = n_fe; o0 = n_ov;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send(8'h00, 1'b1);
    send(8'hFF, 1'b1);
    drain("t6_drain");
    chk("t6_valid_count", n_del - d0, 2);
    chk("t6_errors", (n_fe - f0) + (n_ov - o0), 0);
    clks(4);
    chk("t6_busy", {31'h0, busy}, 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
